// File: rtl/wlm_sched_pkg.sv
// Shared types and sizing helpers for the word-level Montgomery reduction scheduler.
package wlm_sched_pkg;

  // Widest requester id a tag can carry; NREQ must not exceed 2**TAG_ID_W.
  localparam int TAG_ID_W = 8;

  // Requester id width, never narrower than one bit.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Credit counter width, able to hold 0..DEPTH inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One stage of the tag pipeline that shadows the reducer.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/wlm_sched_if.sv
// Requester, reducer and result-side signals of the scheduler, bundled as one interface.
interface wlm_sched_if #(
  parameter int NREQ  = 4,
  parameter int LOGQ  = 60,
  parameter int LOGQH = 17
);
  import wlm_sched_pkg::*;

  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*2*LOGQ-1:0]   req_C;
  logic [NREQ*LOGQH-1:0]    req_qH;

  logic                     dp_valid;
  logic [2*LOGQ-1:0]        dp_C;
  logic [LOGQH-1:0]         dp_qH;
  logic [LOGQ-1:0]          dp_T;

  logic                     res_valid;
  logic                     res_ready;
  logic [LOGQ-1:0]          res_T;
  logic [ID_W-1:0]          res_id;
  logic                     idle;

  // Environment side: requesters, reducer output and result consumer.
  modport master (
    output req_valid, req_C, req_qH, dp_T, res_ready,
    input  req_ready, dp_valid, dp_C, dp_qH, res_valid, res_T, res_id, idle
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_C, req_qH, dp_T, res_ready,
    output req_ready, dp_valid, dp_C, dp_qH, res_valid, res_T, res_id, idle
  );

endinterface

// File: rtl/wlm_res_fifo.sv
// First-word-fall-through result FIFO; rd_data is valid whenever empty is low.
module wlm_res_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;

  // Pointer and occupancy update; a write and a read together keep occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/wlm_sched.sv
// Round-robin scheduler sharing one non-stallable fixed-latency reducer between
// NREQ requesters. Credits cover FIFO slots plus jobs in flight, so a result
// returning from the reducer always has a FIFO slot waiting for it.
module wlm_sched
  import wlm_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LOGQ  = 60,
  parameter int LOGQH = 17,
  parameter int LAT   = 6,
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        rst,
  wlm_sched_if.slave bus
);

  localparam int ID_W   = id_w(NREQ);
  localparam int CRED_W = cred_w(DEPTH);
  localparam int CW     = 2 * LOGQ;
  localparam int FW     = LOGQ + ID_W;

  logic [CRED_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              dp_valid_q, dp_valid_d;
  logic [CW-1:0]     dp_C_q, dp_C_d;
  logic [LOGQH-1:0]  dp_qH_q, dp_qH_d;
  logic [ID_W-1:0]   dp_id_q, dp_id_d;
  tag_t              tag_q [1:LAT];
  tag_t              tag_d [1:LAT];

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic              issue, pop, tag_any;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic [CRED_W-1:0] fifo_count;

  // (base + off) mod NREQ without relying on NREQ being a power of two.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return ID_W'(s);
  endfunction

  // Round-robin search from rr_ptr; descending scan so the nearest requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(rr_ptr_q, k)]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx(rr_ptr_q, k);
      end
    end
  end

  // Grant only with a spare credit; held off entirely while in reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst && grant_vld && (credit_q != '0)) bus.req_ready = NREQ'(1) << grant_id;
  end

  assign issue = |bus.req_ready;
  assign pop   = ~fifo_empty & bus.res_ready;

  // Next-state for credit, pointer, reducer input registers and tag pipeline.
  always_comb begin
    credit_d   = credit_q;
    rr_ptr_d   = rr_ptr_q;
    dp_valid_d = issue;
    dp_C_d     = dp_C_q;
    dp_qH_d    = dp_qH_q;
    dp_id_d    = dp_id_q;
    case ({issue, pop})
      2'b10:   credit_d = credit_q - CRED_W'(1);
      2'b01:   credit_d = credit_q + CRED_W'(1);
      default: credit_d = credit_q;
    endcase
    if (issue) begin
      rr_ptr_d = rr_idx(grant_id, 1);
      dp_C_d   = bus.req_C[int'(grant_id) * CW +: CW];
      dp_qH_d  = bus.req_qH[int'(grant_id) * LOGQH +: LOGQH];
      dp_id_d  = grant_id;
    end
    tag_d[1].valid = dp_valid_q;
    tag_d[1].id    = TAG_ID_W'(dp_id_q);
    for (int k = 2; k <= LAT; k++) tag_d[k] = tag_q[k-1];
  end

  // State registers; reset drops every in-flight tag so stale dp_T is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q   <= CRED_W'(DEPTH);
      rr_ptr_q   <= '0;
      dp_valid_q <= 1'b0;
      dp_C_q     <= '0;
      dp_qH_q    <= '0;
      dp_id_q    <= '0;
      for (int k = 1; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      credit_q   <= credit_d;
      rr_ptr_q   <= rr_ptr_d;
      dp_valid_q <= dp_valid_d;
      dp_C_q     <= dp_C_d;
      dp_qH_q    <= dp_qH_d;
      dp_id_q    <= dp_id_d;
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  // Any tag still travelling through the reducer.
  always_comb begin
    tag_any = 1'b0;
    for (int k = 1; k <= LAT; k++) tag_any = tag_any | tag_q[k].valid;
  end

  wlm_res_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_q[LAT].valid),
    .wr_data ({bus.dp_T, tag_q[LAT].id[ID_W-1:0]}),
    .rd_en   (bus.res_ready),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_C      = dp_C_q;
  assign bus.dp_qH     = dp_qH_q;
  assign bus.res_valid = ~fifo_empty;
  assign bus.res_T     = fifo_rdata[FW-1:ID_W];
  assign bus.res_id    = fifo_rdata[ID_W-1:0];
  assign bus.idle      = ~tag_any & fifo_empty & ~dp_valid_q;

  // A returning result must always find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(tag_q[LAT].valid && fifo_full));

  // Credits plus stored results never exceed the FIFO size.
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    (int'(credit_q) <= DEPTH) && (int'(credit_q) + int'(fifo_count) <= DEPTH));

  // Tag ids are zero-extended requester ids.
  if (ID_W < TAG_ID_W) begin : g_id_chk
    a_id_fits: assert property (@(posedge clk) disable iff (!rst)
      tag_q[LAT].id[TAG_ID_W-1:ID_W] == '0);
  end

endmodule

// File: tb/tb_wlm_sched.sv
// Bench for wlm_sched: stub reducer, queue-based reference model, table and hand sequences.
module tb_wlm_sched;
  import wlm_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int LOGQ  = 60;
  localparam int LOGQH = 17;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;
  localparam int CW    = 2 * LOGQ;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wlm_sched_if #(.NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(LOGQH)) bus ();

  wlm_sched #(.NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(LOGQH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub reducer: T = C[LOGQ-1:0] ^ qH, LAT cycles after the inputs appear.
  logic [LOGQ-1:0] red_pipe [1:LAT];
  always @(posedge clk) begin
    red_pipe[1] <= bus.dp_C[LOGQ-1:0] ^ {{(LOGQ-LOGQH){1'b0}}, bus.dp_qH};
    for (int k = 2; k <= LAT; k++) red_pipe[k] <= red_pipe[k-1];
  end
  assign bus.dp_T = red_pipe[LAT];

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    logic [127:0] r;
    for (int i = 0; i < NREQ; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.req_C[i*CW +: CW]       = r[CW-1:0];
      bus.req_qH[i*LOGQH +: LOGQH] = LOGQH'($urandom());
    end
  endtask

  // Reference model: every accepted job sits in a queue until popped; credit is
  // DEPTH minus the queue size, and a job is visible LAT+2 cycles after acceptance.
  typedef struct {
    logic [LOGQ-1:0] t;
    int              id;
    longint          rdy;
  } job_t;

  job_t            sb[$];
  job_t            m_job;
  int              rr_m = 0;
  logic            prev_hs = 1'b0;
  logic [CW-1:0]   prev_C;
  logic [LOGQH-1:0] prev_qH;
  logic [NREQ-1:0] m_rdy;
  logic            m_rv;
  int              m_g;
  int              m_idx;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      sb.delete();
      rr_m    = 0;
      prev_hs = 1'b0;
    end else begin
      m_rdy = '0;
      m_g   = -1;
      if (DEPTH - sb.size() > 0) begin
        for (int k = 0; k < NREQ; k++) begin
          m_idx = (rr_m + k) % NREQ;
          if (bus.req_valid[m_idx] && m_g < 0) m_g = m_idx;
        end
      end
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      chk("req_ready", bus.req_ready, m_rdy);
      chk("dp_valid", bus.dp_valid, prev_hs);
      if (prev_hs) begin
        chk("dp_C", bus.dp_C, prev_C);
        chk("dp_qH", bus.dp_qH, prev_qH);
      end
      chk("idle", bus.idle, sb.size() == 0);
      m_rv = (sb.size() > 0) && (sb[0].rdy <= cyc);
      chk("res_valid", bus.res_valid, m_rv);
      if (m_rv && bus.res_valid) begin
        chk("res_T", bus.res_T, sb[0].t);
        chk("res_id", bus.res_id, sb[0].id);
      end
      prev_hs = 1'b0;
      if (m_g >= 0) begin
        prev_C   = bus.req_C[m_g*CW +: CW];
        prev_qH  = bus.req_qH[m_g*LOGQH +: LOGQH];
        m_job.t  = prev_C[LOGQ-1:0] ^ {{(LOGQ-LOGQH){1'b0}}, prev_qH};
        m_job.id = m_g;
        m_job.rdy = cyc + LAT + 2;
        sb.push_back(m_job);
        rr_m    = (m_g + 1) % NREQ;
        prev_hs = 1'b1;
      end
      if (m_rv && bus.res_ready) void'(sb.pop_front());
    end
  end

  task automatic pulse_rst();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Credit exhaustion with res_ready low, then a one-cycle pop.
  task automatic backpressure(input string tag);
    int n;
    n = 0;
    bus.res_ready = 1'b0;
    bus.req_valid = '1;
    for (int k = 0; k < 20; k++) begin
      rand_ops();
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) n++;
      step();
    end
    chk({tag, "_handshakes"}, n, 8);
    @(negedge clk);
    chk({tag, "_stalled"}, bus.req_ready, 0);
    step();
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_pop_cycle_ready"}, bus.req_ready, 0);
    chk({tag, "_pop_cycle_valid"}, bus.res_valid, 1);
    step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_one_grant"}, $countones(bus.req_ready), 1);
    step();
    @(negedge clk);
    chk({tag, "_after_grant"}, bus.req_ready, 0);
    step();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk({tag, "_drained_idle"}, bus.idle, 1);
    step();
  endtask

  typedef struct {
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] rdy;
  } vec_t;

  vec_t tbl[12];
  logic [CW-1:0]    sv_C;
  logic [LOGQH-1:0] sv_qH;
  int last_g;
  int g;

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b1010, 4'b0010};
    tbl[2]  = '{4'b1010, 4'b1000};
    tbl[3]  = '{4'b1010, 4'b0010};
    tbl[4]  = '{4'b1010, 4'b1000};
    tbl[5]  = '{4'b0001, 4'b0001};
    tbl[6]  = '{4'b1111, 4'b0010};
    tbl[7]  = '{4'b1111, 4'b0100};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b1001, 4'b1000};
    tbl[11] = '{4'b1001, 4'b0001};

    bus.req_valid = '1;
    bus.req_C     = '0;
    bus.req_qH    = '0;
    bus.res_ready = 1'b0;
    rst           = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_dp_valid", bus.dp_valid, 0);
    chk("rst_dp_C", bus.dp_C, 0);
    chk("rst_dp_qH", bus.dp_qH, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_idle", bus.idle, 1);
    bus.req_valid = '0;
    rst = 1'b1;
    bus.res_ready = 1'b1;
    repeat (2) step();

    // Single job from requester 2.
    bus.req_C[2*CW +: CW]          = 120'h5;
    bus.req_qH[2*LOGQH +: LOGQH]   = 17'h3;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("a_grant", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("a_dp_valid", bus.dp_valid, 1);
    chk("a_dp_C", bus.dp_C, 120'h5);
    chk("a_dp_qH", bus.dp_qH, 17'h3);
    for (int k = 2; k < LAT + 2; k++) begin
      step();
      @(negedge clk);
      chk("a_res_early", bus.res_valid, 0);
    end
    step();
    @(negedge clk);
    chk("a_res_valid", bus.res_valid, 1);
    chk("a_res_T", bus.res_T, 60'h6);
    chk("a_res_id", bus.res_id, 2);
    step();
    @(negedge clk);
    chk("a_idle_after_pop", bus.idle, 1);
    step();

    // Arbitration table from a freshly reset pointer.
    pulse_rst();
    bus.res_ready = 1'b1;
    foreach (tbl[i]) begin
      rand_ops();
      bus.req_valid = tbl[i].rv;
      @(negedge clk);
      chk("tbl_ready", bus.req_ready, tbl[i].rdy);
      step();
    end
    bus.req_valid = '0;
    repeat (12) step();

    // All requesters busy with free-flowing results: strict rotation.
    last_g = -1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rand_ops();
      @(negedge clk);
      if (|bus.req_ready) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        if (last_g >= 0) chk("rr_order", g, (last_g + 1) % NREQ);
        last_g = g;
      end
      step();
    end
    bus.req_valid = '0;
    repeat (12) step();

    backpressure("bp");

    // Reset with three jobs in flight and two results queued.
    bus.res_ready = 1'b0;
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("c_pre_res_valid", bus.res_valid, 1);
    chk("c_pre_idle", bus.idle, 0);
    step();
    bus.req_valid = '1;
    rst = 1'b0;
    #1;
    chk("c_rst_res_valid", bus.res_valid, 0);
    chk("c_rst_idle", bus.idle, 1);
    chk("c_rst_req_ready", bus.req_ready, 0);
    step();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("c_no_stale", bus.res_valid, 0);
      step();
    end
    rand_ops();
    sv_C  = bus.req_C[1*CW +: CW];
    sv_qH = bus.req_qH[1*LOGQH +: LOGQH];
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("c_grant", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    repeat (LAT + 1) step();
    @(negedge clk);
    chk("c_res_valid", bus.res_valid, 1);
    chk("c_res_id", bus.res_id, 1);
    chk("c_res_T", bus.res_T, sv_C[LOGQ-1:0] ^ {{(LOGQ-LOGQH){1'b0}}, sv_qH});
    step();
    backpressure("c_bp");

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      bus.req_valid = NREQ'($urandom());
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (30) step();
    @(negedge clk);
    chk("final_idle", bus.idle, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
